// File: rtl/ofs_fim_tag_remap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ofs_fim_tag_remap_pkg
// Description : Shared types and constants for the request/completion tag
//               remapper (tag and UID types, header structs, skid depth).
// Revision    : 1.0 - initial release
// ============================================================================
package ofs_fim_tag_remap_pkg;

   localparam int PKG_N_ENTRIES  = 32;
   localparam int PKG_UW         = $clog2(PKG_N_ENTRIES);
   localparam int PKG_ORIG_TAG_W = 10;
   localparam int PKG_HDR_W      = 128;

   // Both skid buffers hold two entries: enough to keep one transfer per
   // cycle while letting input ready come purely from a registered count.
   localparam int SKID_DEPTH     = 2;

   typedef logic [PKG_ORIG_TAG_W-1:0] t_orig_tag;
   typedef logic [PKG_UW-1:0]         t_uid;

   // Outbound request as forwarded to the PCIe side.
   typedef struct packed {
      logic [PKG_HDR_W-1:0] hdr;
      t_uid                 uid;
   } t_req_hdr;

   // Completion after its tag has been restored for the AFU side.
   typedef struct packed {
      logic [PKG_HDR_W-1:0] hdr;
      t_orig_tag            tag;
   } t_cpl_hdr;

endpackage
`default_nettype wire

// File: rtl/ofs_fim_tag_remap_skid.sv
`default_nettype none
// ============================================================================
// Module      : ofs_fim_tag_remap_skid
// Description : Two-entry valid/ready skid buffer. Input ready depends only
//               on the registered fill count, never on either valid.
// Revision    : 1.0 - initial release
// ============================================================================
module ofs_fim_tag_remap_skid
   import ofs_fim_tag_remap_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_in_data,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_out_data
);

   logic [WIDTH-1:0] r_mem [SKID_DEPTH];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;
   logic             w_push;
   logic             w_pop;

   assign o_in_ready  = (r_count != 2'(SKID_DEPTH));
   assign o_out_valid = (r_count != 2'd0);
   assign o_out_data  = r_mem[r_rd_ptr];
   assign w_push      = i_in_valid && o_in_ready;
   assign w_pop       = o_out_valid && i_out_ready;

   // Pointer and occupancy tracking; a reset drops anything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage; contents are only meaningful where the count says so.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_in_data;
   end

endmodule
`default_nettype wire

// File: rtl/ofs_fim_tag_remap_req.sv
`default_nettype none
// ============================================================================
// Module      : ofs_fim_tag_remap_req
// Description : Replaces AFU request tags with pool UIDs, restores the
//               original tag on returning completions and releases the UID
//               on the final completion. Optional statistics/error tracking
//               is enabled by defining OFS_FIM_TAG_REMAP_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ofs_fim_tag_remap_req
   import ofs_fim_tag_remap_pkg::*;
#(
   parameter  int N_ENTRIES  = PKG_N_ENTRIES,
   parameter  int ORIG_TAG_W = PKG_ORIG_TAG_W,
   parameter  int HDR_W      = PKG_HDR_W,
   localparam int UW         = $clog2(N_ENTRIES)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // AFU-side requests
   input  logic                  req_in_valid,
   output logic                  req_in_ready,
   input  logic [HDR_W-1:0]      req_in_hdr,
   input  logic [ORIG_TAG_W-1:0] req_in_tag,
   // PCIe-side requests
   output logic                  req_out_valid,
   input  logic                  req_out_ready,
   output logic [HDR_W-1:0]      req_out_hdr,
   output logic [UW-1:0]         req_out_tag,
   // Tag pool
   output logic                  alloc,
   input  logic                  alloc_ready,
   input  logic [UW-1:0]         alloc_uid,
   output logic                  free,
   output logic [UW-1:0]         free_uid,
   // PCIe-side completions
   input  logic                  cpl_in_valid,
   output logic                  cpl_in_ready,
   input  logic [HDR_W-1:0]      cpl_in_hdr,
   input  logic [UW-1:0]         cpl_in_tag,
   input  logic                  cpl_in_last,
   // AFU-side completions
   output logic                  cpl_out_valid,
   input  logic                  cpl_out_ready,
   output logic [HDR_W-1:0]      cpl_out_hdr,
   output logic [ORIG_TAG_W-1:0] cpl_out_tag,
   // Status
   output logic                  err_unexp_cpl
);

   logic                  r_run;
   logic                  w_req_skid_ready;
   logic                  w_cpl_skid_ready;
   logic                  w_req_accept;
   logic                  w_cpl_accept;
   logic [ORIG_TAG_W-1:0] w_cpl_orig_tag;
   logic [ORIG_TAG_W-1:0] r_tag_ram [N_ENTRIES];
   logic                  r_free;
   logic [UW-1:0]         r_free_uid;

   // Holds both input readies low during reset and for the first cycle after.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_run <= 1'b0;
      else        r_run <= 1'b1;
   end

   // Request path: accept only when a UID exists and the skid has room.
   assign req_in_ready = r_run && alloc_ready && w_req_skid_ready;
   assign w_req_accept = req_in_valid && req_in_ready;
   assign alloc        = w_req_accept;

   // Completion path: lookup is asynchronous so the restored tag is pushed
   // alongside the header in the accepting cycle.
   assign cpl_in_ready   = r_run && w_cpl_skid_ready;
   assign w_cpl_accept   = cpl_in_valid && cpl_in_ready;
   assign w_cpl_orig_tag = r_tag_ram[cpl_in_tag];

   // Tag table write; a UID is never rewritten before its release reaches
   // the pool, so no read/write bypass is needed.
   always_ff @(posedge clk) begin
      if (w_req_accept) r_tag_ram[alloc_uid] <= req_in_tag;
   end

   // One-cycle release strobe for the UID of a final completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_free     <= 1'b0;
         r_free_uid <= '0;
      end else begin
         r_free <= w_cpl_accept && cpl_in_last;
         if (w_cpl_accept && cpl_in_last) r_free_uid <= cpl_in_tag;
      end
   end

   assign free     = r_free;
   assign free_uid = r_free_uid;

   ofs_fim_tag_remap_skid #(
      .WIDTH (HDR_W + UW)
   ) u_req_skid (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_in_valid  (w_req_accept),
      .o_in_ready  (w_req_skid_ready),
      .i_in_data   ({req_in_hdr, alloc_uid}),
      .o_out_valid (req_out_valid),
      .i_out_ready (req_out_ready),
      .o_out_data  ({req_out_hdr, req_out_tag})
   );

   ofs_fim_tag_remap_skid #(
      .WIDTH (HDR_W + ORIG_TAG_W)
   ) u_cpl_skid (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_in_valid  (w_cpl_accept),
      .o_in_ready  (w_cpl_skid_ready),
      .i_in_data   ({cpl_in_hdr, w_cpl_orig_tag}),
      .o_out_valid (cpl_out_valid),
      .i_out_ready (cpl_out_ready),
      .o_out_data  ({cpl_out_hdr, cpl_out_tag})
   );

`ifdef OFS_FIM_TAG_REMAP_STATS_EN
   logic [N_ENTRIES-1:0] r_busy;
   logic                 r_err_unexp;
   logic [UW:0]          r_outstanding;
   logic                 w_cpl_busy;
   logic                 w_release;

   assign w_cpl_busy = r_busy[cpl_in_tag];
   assign w_release  = w_cpl_accept && cpl_in_last && w_cpl_busy;

   // Busy bit per UID; set and clear never hit the same UID in one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= '0;
      end else begin
         if (w_req_accept)                r_busy[alloc_uid]  <= 1'b1;
         if (w_cpl_accept && cpl_in_last) r_busy[cpl_in_tag] <= 1'b0;
      end
   end

   // Sticky flag for a completion whose UID was never handed out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          r_err_unexp <= 1'b0;
      else if (w_cpl_accept && !w_cpl_busy) r_err_unexp <= 1'b1;
   end

   // Outstanding count; only genuine releases decrement it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_outstanding <= '0;
      end else begin
         case ({w_req_accept, w_release})
            2'b10:   r_outstanding <= r_outstanding + 1'b1;
            2'b01:   r_outstanding <= r_outstanding - 1'b1;
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   assign err_unexp_cpl = r_err_unexp;

`ifndef SYNTHESIS
   ap_outstanding_bound: assert property (@(posedge clk) disable iff (!rst_n)
      r_outstanding <= (UW+1)'(N_ENTRIES));
`endif
`else
   assign err_unexp_cpl = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/ofs_fim_tag_remap_req.md
# ofs_fim_tag_remap_req

Request/completion tag remapper that consumes UIDs from `ofs_fim_tag_pool`. Outbound read-request headers carry a requester tag from the AFU side; the block replaces it with a pool-allocated UID and saves the original. Returning completions are restored to the original tag, and on the final completion the UID is released back to the pool. The block sits between the AFU-facing TX/RX header streams and the PCIe-facing streams.

## Interface
- `N_ENTRIES`, 32: pool size; UID width `UW = $clog2(N_ENTRIES)`.
- `ORIG_TAG_W`, 10: width of the AFU-side original tag.
- `HDR_W`, 128: header payload width, excluding the tag field.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_in_valid`, `req_in_ready`  in/out  1  AFU request handshake.
- `req_in_hdr`, `req_in_tag`  in  `HDR_W`/`ORIG_TAG_W`  request header and original tag.
- `req_out_valid`, `req_out_ready`  out/in  1  PCIe-side request handshake.
- `req_out_hdr`, `req_out_tag`  out  `HDR_W`/`UW`  forwarded header and remapped UID.
- `alloc`  out  1  pops the pool.
- `alloc_ready`  in  1  a UID is available.
- `alloc_uid`  in  `UW`  head UID.
- `free`  out  1  release strobe to the pool.
- `free_uid`  out  `UW`  UID being released.
- `cpl_in_valid`, `cpl_in_ready`  in/out  1  PCIe completion handshake.
- `cpl_in_hdr`, `cpl_in_tag`, `cpl_in_last`  in  `HDR_W`/`UW`/1  completion header, UID, final-completion flag for that tag.
- `cpl_out_valid`, `cpl_out_ready`  out/in  1  AFU completion handshake.
- `cpl_out_hdr`, `cpl_out_tag`  out  `HDR_W`/`ORIG_TAG_W`  restored completion.
- `err_unexp_cpl`  out  1  sticky flag; present only with the stats feature.

## Operation
- **Request path.** `req_in_ready = alloc_ready && !req_skid_full`. A request is accepted when `req_in_valid && req_in_ready`. On accept:
  - `alloc` is pulsed combinationally in the same cycle.
  - `tag_ram[alloc_uid] <= req_in_tag` is written.
  - The header with `alloc_uid` is pushed into a 2-entry skid buffer that drives `req_out_*`.
- **Completion path.** `cpl_in_ready = !cpl_skid_full`. On accept, `tag_ram[cpl_in_tag]` is read asynchronously (distributed RAM) and `{hdr, orig_tag}` is pushed into a 2-entry skid buffer that drives `cpl_out_*`.
- **Release.** On an accepted completion with `cpl_in_last=1`, register `free <= 1` and `free_uid <= cpl_in_tag` for exactly one cycle. At most one free per cycle.
- **Table hazard.** None. A UID cannot be reallocated until the pool has seen `free`, so the earliest rewrite comes ≥2 cycles after the final read.
- **Simultaneous events.** A request accept and a completion accept in the same cycle are independent: one RAM write and one RAM read at different addresses.
- **Outputs.** Valid outputs are stable until their ready is seen (AXI-S rules). Ready must never depend combinationally on the same-side valid.

## Timing
- Reset values: `req_out_valid=0`, `cpl_out_valid=0`, `alloc=0`, `free=0`, `free_uid=0`, `err_unexp_cpl=0`, `req_in_ready=0`, `cpl_in_ready=0`. Skid buffers are empty. The tag RAM is not reset.
- Request latency: 1 cycle from accept to `req_out_valid`. Sustained throughput is 1/cycle while the pool and `req_out_ready` allow.
- Completion latency: 1 cycle from accept to `cpl_out_valid`. `free` is asserted 1 cycle after the accepting edge.
- Backpressure: a skid buffer deasserts its input ready only when both entries are full. Full throughput is preserved with `*_out_ready` held high.
- Empty pool: `alloc_ready=0` forces `req_in_ready=0`. There is no speculative alloc.
- Reset mid-operation: all in-flight headers are discarded and no `free` is issued. The pool resets on the same `rst_n`, so UID ownership stays consistent.

## Configuration
- `OFS_FIM_TAG_REMAP_STATS_EN` defined: add an `N_ENTRIES` busy-bit vector.
  - Set on alloc; cleared on last completion.
  - A completion whose UID is not busy sets `err_unexp_cpl`, which holds until reset. The completion is still forwarded.
  - Add an outstanding counter (`UW+1` bits) with a simulation assertion that it never exceeds `N_ENTRIES`.
- Undefined: no busy vector, no counter. `err_unexp_cpl` is tied to 0.

## Structure
- Shared package `ofs_fim_tag_remap_pkg`: `t_orig_tag`, `t_uid` (parameterised via `localparam`), the request/completion header structs, and the skid-buffer depth constant.
- One sub-module, `ofs_fim_tag_remap_skid`: a 2-entry valid/ready skid buffer parameterised by width, instantiated twice.

## Test plan
- **Single read.** Request with tag 0x2A5 and pool UID 3 → `req_out_tag=3` one cycle later. Completion tag 3 with last=1 → `cpl_out_tag=0x2A5`, `free=1`, `free_uid=3`.
- **Split completion.** Three completions for UID 7, only the third with last=1 → three restored outputs, exactly one `free` pulse, after the third.
- **Pool exhaustion.** Hold 32 outstanding requests with `alloc_ready=0` → `req_in_ready=0` and no `alloc`. Free one → the next request is accepted with that UID.
- **Backpressure.** Hold `req_out_ready=0` with continuous requests → exactly 2 accepted, then `req_in_ready=0`. Release → order preserved and no drop.
- **Concurrent traffic.** Request accept and completion accept in the same cycle, with random readies for 10k transactions → scoreboard matches every original tag, and the pool shows no leaked UIDs.
- **Stats (macro on).** Completion with an idle UID 9 → `err_unexp_cpl=1` and stays set. Reset mid-traffic → all outputs return to their reset values and the counter reads 0.
